// File: rtl/or_arb_pkg.sv
// Shared types and helpers for the or_rr_arbiter slice.
package or_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/or_arb_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, wrapping.
module or_arb_pick
  import or_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned pos;
  int unsigned sel;
  logic        found;

  always_comb begin
    pos   = 0;
    sel   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        found = 1'b1;
        sel   = pos;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      gnt[j] = found && (sel == j);
    end
  end

  assign idx = IDW'(sel);
  assign any = found;

endmodule

// File: rtl/or_gate.sv
// Shared bitwise OR datapath unit.
module or_gate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a | b;

endmodule

// File: rtl/or_rr_arbiter.sv
// Round-robin arbiter sharing one or_gate between NREQ requesters.
// Define OR_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority (no ptr).
module or_rr_arbiter
  import or_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = idw(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ*WIDTH-1:0] REQ_IN0,
  input  logic [NREQ*WIDTH-1:0] REQ_IN1,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [WIDTH-1:0]      RSP_OUT0,
  output logic [IDW-1:0]        RSP_ID
);

  state_t           state;
  logic [IDW-1:0]   pick_ptr;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   win;
  logic             pick_any;
  logic             can_accept;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] or_y;

`ifdef OR_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDW-1:0] ptr;
  assign pick_ptr = ptr;
`endif

  or_arb_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (REQ_VALID),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (win),
    .any (pick_any)
  );

  // Reset masks the grant so nothing handshakes while the block is being cleared.
  assign can_accept = (state == ST_EMPTY) || RSP_READY;
  assign grant      = can_accept && pick_any && !RST;
  assign REQ_READY  = grant ? pick_gnt : '0;

  assign op_a = REQ_IN0[win*WIDTH +: WIDTH];
  assign op_b = REQ_IN1[win*WIDTH +: WIDTH];

  or_gate #(
    .WIDTH (WIDTH)
  ) u_or (
    .a (op_a),
    .b (op_b),
    .y (or_y)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_EMPTY;
      RSP_OUT0 <= '0;
      RSP_ID   <= '0;
`ifndef OR_ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else if (grant) begin
      state    <= ST_FULL;
      RSP_OUT0 <= or_y;
      RSP_ID   <= win;
`ifndef OR_ARB_FIXED_PRIO_EN
      ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
    end else if (RSP_READY) begin
      state <= ST_EMPTY;
    end
  end

  assign RSP_VALID = (state == ST_FULL);

endmodule

// File: tb/tb_or_rr_arbiter.sv
// Self-checking bench for or_rr_arbiter against a transaction-level reference model.
module tb_or_rr_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   rq_valid;
  logic [N-1:0]   rq_ready;
  logic [N*W-1:0] in0;
  logic [N*W-1:0] in1;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_out;
  logic [1:0]     rsp_id;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_ptr;
  bit         m_full;
  logic [7:0] m_out;
  int         m_id;

  always #5 clk = ~clk;

  or_rr_arbiter #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VALID (rq_valid),
    .REQ_READY (rq_ready),
    .REQ_IN0   (in0),
    .REQ_IN1   (in1),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_OUT0  (rsp_out),
    .RSP_ID    (rsp_id)
  );

  function automatic int pick(input logic [N-1:0] v);
    int base;
`ifdef OR_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    if (rst) return '0;
    if (m_full && !rsp_ready) return '0;
    w = pick(rq_valid);
    if (w < 0) return '0;
    return 4'b0001 << w;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic step();
    logic [N-1:0] r;
    int           w;
    int           n_ptr;
    bit           n_full;
    logic [7:0]   n_out;
    int           n_id;
    r = exp_ready();
    n_ptr = m_ptr; n_full = m_full; n_out = m_out; n_id = m_id;
    if (rst) begin
      n_ptr = 0; n_full = 0; n_out = '0; n_id = 0;
    end else if (r != '0) begin
      w = pick(rq_valid);
      n_out  = in0[w*W +: W] | in1[w*W +: W];
      n_id   = w;
      n_full = 1;
      n_ptr  = (w + 1) % N;
    end else if (rsp_ready) begin
      n_full = 0;
    end
    @(posedge clk);
    #1;
    m_ptr = n_ptr; m_full = n_full; m_out = n_out; m_id = n_id;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rq_valid = '1; rsp_ready = 1'b1;
    in0 = 32'hFFFF_FFFF; in1 = 32'h1234_5678;
    step();
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++;
    if (rsp_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", rsp_out); end
    checks++;
    if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    checks++;
    if (rq_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", rq_ready); end
    rst = 1'b0; rq_valid = '0;
    step();
  endtask

  task automatic test_single();
    rq_valid = 4'b0100; rsp_ready = 1'b1;
    in0 = '0; in1 = '0;
    in0[2*W +: W] = 8'hA0; in1[2*W +: W] = 8'h05;
    #1;
    checks++;
    if (rq_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", rq_ready); end
    step();
    rq_valid = '0;
    #1;
    checks++;
    if (rq_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop got %b want 0000", rq_ready); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 8'hA5 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL single_rsp got v=%b out=%h id=%0d want v=1 out=a5 id=2", rsp_valid, rsp_out, rsp_id);
    end
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_consume got %b want 0", rsp_valid); end
  endtask

  task automatic test_saturated();
    int exp_id;
    do_reset();
    rq_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in0 = {$urandom, $urandom} ; in1 = $urandom;
`ifdef OR_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % N;
`endif
      #1;
      checks++;
      if (rq_ready !== (4'b0001 << exp_id)) begin
        errors++; $display("FAIL sat_ready[%0d] got %b want one-hot %0d", i, rq_ready, exp_id);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_out !== m_out) begin
        errors++; $display("FAIL sat_rsp[%0d] got v=%b id=%0d out=%h want v=1 id=%0d out=%h", i, rsp_valid, rsp_id, rsp_out, exp_id, m_out);
      end
    end
    rq_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    int         grants;
    logic [7:0] held_out;
    logic [1:0] held_id;
    do_reset();
    grants = 0;
    rq_valid = 4'b0010; rsp_ready = 1'b0;
    in0 = 32'h0000_3000; in1 = 32'h0000_0C00;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rq_ready != 4'b0000) grants++;
      if (i > 0) begin
        checks++;
        if (rq_ready !== 4'b0000 || rsp_out !== held_out || rsp_id !== held_id || rsp_valid !== 1'b1) begin
          errors++; $display("FAIL bp_hold[%0d] got rdy=%b out=%h id=%0d v=%b want 0000 %h %0d 1", i, rq_ready, rsp_out, rsp_id, rsp_valid, held_out, held_id);
        end
      end
      step();
      held_out = 8'h3C; held_id = 2'd1;
      in0[1*W +: W] = 8'h81; in1[1*W +: W] = 8'h18;
    end
    checks++;
    if (grants !== 1) begin errors++; $display("FAIL bp_grants got %0d want 1", grants); end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (rq_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b want 0010", rq_ready); end
    step();
    rq_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 8'h99 || rsp_id !== 2'd1) begin
      errors++; $display("FAIL bp_next got v=%b out=%h id=%0d want 1 99 1", rsp_valid, rsp_out, rsp_id);
    end
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    rq_valid = '1; rsp_ready = 1'b1;
    in0 = $urandom; in1 = $urandom;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_out !== 8'h00) begin
      errors++; $display("FAIL midrst_clear got v=%b out=%h want 0 00", rsp_valid, rsp_out);
    end
    checks++;
    if (rq_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ready got %b want 0001", rq_ready); end
    step();
    checks++;
    if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_id got id=%0d v=%b want 0 1", rsp_id, rsp_valid);
    end
    rq_valid = '0;
    step();
  endtask

  task automatic test_skip();
    logic [1:0] first;
    logic [1:0] second;
`ifdef OR_ARB_FIXED_PRIO_EN
    first = 2'd0; second = 2'd0;
`else
    first = 2'd3; second = 2'd0;
`endif
    do_reset();
    rq_valid = 4'b0001; rsp_ready = 1'b1;
    step();
    rq_valid = 4'b1001;
    #1;
    checks++;
    if (rq_ready !== (4'b0001 << first)) begin errors++; $display("FAIL skip_ready1 got %b want idx %0d", rq_ready, first); end
    step();
    checks++;
    if (rsp_id !== first) begin errors++; $display("FAIL skip_id1 got %0d want %0d", rsp_id, first); end
    #1;
    checks++;
    if (rq_ready !== (4'b0001 << second)) begin errors++; $display("FAIL skip_ready2 got %b want idx %0d", rq_ready, second); end
    step();
    checks++;
    if (rsp_id !== second) begin errors++; $display("FAIL skip_id2 got %0d want %0d", rsp_id, second); end
    rq_valid = '0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      rq_valid  = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      in0 = $urandom; in1 = $urandom;
      #1;
      er = exp_ready();
      checks++;
      if (rq_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, rq_ready, er); end
      checks++;
      if (rsp_valid !== m_full || (m_full && (rsp_out !== m_out || rsp_id !== 2'(m_id)))) begin
        errors++; $display("FAIL rand_rsp[%0d] got v=%b out=%h id=%0d want v=%b out=%h id=%0d", i, rsp_valid, rsp_out, rsp_id, m_full, m_out, m_id);
      end
      step();
    end
    rst = 1'b0; rq_valid = '0;
  endtask

  initial begin
    rst = 1'b1; rq_valid = '0; rsp_ready = 1'b0; in0 = '0; in1 = '0;
    m_ptr = 0; m_full = 0; m_out = '0; m_id = 0;
    test_reset();
    test_single();
    test_saturated();
    test_backpressure();
    test_mid_reset();
    test_skip();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/or_rr_arbiter.md
# or_rr_arbiter

Round-robin arbiter that shares a single `or_gate` datapath (WIDTH bits) between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The winner's operands are ORed and the result is captured in a one-entry output register. The result is returned with the winner's index on a valid/ready response channel. The block sits between several client engines and the shared bitwise unit, and sequences all access to it.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), requester-index width (derived, not overridden)

- CLK  input  1  clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- REQ_VALID  input  NREQ  per-requester request valid
- REQ_READY  output  NREQ  per-requester accept; at most one bit set
- REQ_IN0  input  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- REQ_IN1  input  NREQ*WIDTH  operand B; same packing
- RSP_VALID  output  1  response register holds a result
- RSP_READY  input  1  consumer accepts the response
- RSP_OUT0  output  WIDTH  REQ_IN0[w] | REQ_IN1[w] of the winner w
- RSP_ID  output  IDW  index of the winner

## Operation
- FSM has two states, on the output register:
  - EMPTY: RSP_VALID=0.
  - FULL: RSP_VALID=1.
- Accept condition: `can_accept = (state==EMPTY) || RSP_READY`.
- When can_accept and |REQ_VALID:
  - The picker chooses winner w, the first set REQ_VALID bit scanning from `ptr` upward, modulo NREQ.
  - REQ_READY[w]=1 combinationally. All other REQ_READY bits are 0.
  - Next edge: RSP_OUT0 ← OR result, RSP_ID ← w, state ← FULL, ptr ← (w+1) mod NREQ.
- When can_accept and no REQ_VALID: REQ_READY=0. If RSP_READY is high, state goes FULL→EMPTY. ptr is unchanged.
- When FULL and !RSP_READY: REQ_READY=0, and RSP_OUT0, RSP_ID and RSP_VALID hold stable.
- Simultaneous response consumed and new grant: the register reloads and the state stays FULL. This gives a throughput of 1 result per cycle.
- REQ_READY never depends on RSP_VALID of the same requester. There is no combinational path from REQ_READY back to REQ_VALID.
- A requester that deasserts REQ_VALID before being granted is simply skipped. It is illegal for a requester to drop VALID while READY is high in the same cycle.
- ptr wraps from NREQ-1 to 0.
- Bits of REQ_READY above NREQ do not exist; there is no padding.

## Timing
- Reset values:
  - state=EMPTY, RSP_VALID=0, RSP_OUT0=0, RSP_ID=0, ptr=0, REQ_READY=0.
- RST asserted mid-transaction: the next edge discards any held result. A request that is handshaking in that same cycle is dropped, with no response.
- Latency:
  - Request accepted at edge N gives RSP_VALID=1 after edge N.
  - The result is visible in cycle N+1.
- REQ_READY is combinational from REQ_VALID, state, RSP_READY and ptr. The datapath is combinational; only the output register is sequential.
- Fairness: with all requesters continuously valid and RSP_READY=1, each requester is granted exactly once every NREQ cycles.

## Configuration
- `OR_ARB_FIXED_PRIO_EN` defined:
  - ptr is removed.
  - The winner is always the lowest-index valid requester.
  - Starvation of high indices is allowed.
- Not defined (default): round-robin behaviour as above.
- The handshake, latency and reset values are identical in both builds.

## Structure
- Package `or_arb_pkg` holds:
  - the state enum (ST_EMPTY, ST_FULL);
  - the function `idw(n)` that returns the index width.
- Sub-module `or_arb_pick`: combinational rotate-priority picker.
  - Inputs: request vector and ptr.
  - Outputs: one-hot grant and encoded index.
  - Under the macro, ptr is tied to 0.
- The datapath is one existing `or_gate` instance with WIDTH, fed by a mux on the winner index.

## Test plan
All scenarios use WIDTH=8, NREQ=4 unless stated.
- **Reset check:** hold RST 2 cycles while driving all REQ_VALID → RSP_VALID=0, RSP_OUT0=0x00, RSP_ID=0, REQ_READY=0000.
- **Single request:** req2 with IN0=0xA0, IN1=0x05, RSP_READY=1 → REQ_READY=0100 for 1 cycle, next cycle RSP_OUT0=0xA5, RSP_ID=2.
- **Saturated round-robin:** all four valid for 8 cycles, RSP_READY=1 → RSP_ID sequence 0,1,2,3,0,1,2,3. With `OR_ARB_FIXED_PRIO_EN` the sequence is all 0.
- **Backpressure:** RSP_READY=0 for 5 cycles with req1 valid → exactly one grant, then REQ_READY=0000 and RSP_OUT0/RSP_ID stable. Raising RSP_READY consumes that result and grants req1's next beat in the same cycle.
- **Mid-operation reset:** RST asserted while FULL and a new grant is in flight → next cycle RSP_VALID=0 and ptr=0; the next grant with all valid goes to requester 0.
- **Skipped requester:** ptr=1, only req0 and req3 valid → grant 3, then grant 0.
